// File: rtl/timer_regs.sv
// Register front end for the timing block: bus decode, timer control pulses,
// readback of timer state, and the sticky terminal-count interrupt.
module timer_regs #(
  parameter int          ADDR_W     = 4,
  parameter logic [31:0] TERM_RESET = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_wstrb,
  output logic              bus_ack,
  output logic [31:0]       bus_rdata,
  output logic              ro_trig_start,
  output logic              ro_trig_halt,
  output logic              ro_mode,
  output logic [31:0]       ro_termcount,
  input  logic              rf_status,
  input  logic [31:0]       rf_currcount,
  input  logic              rf_int,
  output logic              irq
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  localparam logic [1:0] W_CTRL   = 2'd0;
  localparam logic [1:0] W_TERM   = 2'd1;
  localparam logic [1:0] W_STATUS = 2'd2;
  localparam logic [1:0] W_COUNT  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        halt_q, halt_d;
  logic        mode_q, mode_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic [31:0] term_q, term_d;
  logic [31:0] rd_val;
  logic        capture;
  logic        in_win;
  logic        pend_clr;
  logic [1:0]  word;
  logic        unused_addr;

  assign unused_addr = ^bus_addr[1:0];
  assign word        = bus_addr[3:2];
  assign in_win      = ADDR_W'(bus_addr >> 4) == '0;
  assign capture     = (state_q == S_IDLE) && bus_req;

  always_comb begin
    rd_val = '0;
    case (word)
      W_CTRL:   rd_val = {28'd0, ie_q, mode_q, 2'b00};
      W_TERM:   rd_val = term_q;
      W_STATUS: rd_val = {30'd0, pend_q, rf_status};
      W_COUNT:  rd_val = rf_currcount;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = '0;
    start_d  = 1'b0;
    halt_d   = 1'b0;
    mode_d   = mode_q;
    ie_d     = ie_q;
    term_d   = term_q;
    pend_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_ACK;
          if (!bus_we) begin
            rdata_d = in_win ? rd_val : '0;
          end else if (in_win) begin
            case (word)
              W_CTRL: if (bus_wstrb[0]) begin
                // HALT takes priority when both bits are written together
                halt_d  = bus_wdata[1];
                start_d = bus_wdata[0] & ~bus_wdata[1];
                mode_d  = bus_wdata[2];
                ie_d    = bus_wdata[3];
              end
              W_TERM: begin
                for (int b = 0; b < 4; b++) begin
                  if (bus_wstrb[b]) term_d[8*b +: 8] = bus_wdata[8*b +: 8];
                end
              end
              W_STATUS: pend_clr = bus_wstrb[0] & bus_wdata[1];
              default: ;
            endcase
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new terminal-count pulse beats a simultaneous clear
  assign pend_d = rf_int | (pend_q & ~pend_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      start_q <= 1'b0;
      halt_q  <= 1'b0;
      mode_q  <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      term_q  <= TERM_RESET;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      halt_q  <= halt_d;
      mode_q  <= mode_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      term_q  <= term_d;
    end
  end

  assign bus_ack       = (state_q == S_ACK);
  assign bus_rdata     = rdata_q;
  assign ro_trig_start = start_q;
  assign ro_trig_halt  = halt_q;
  assign ro_mode       = mode_q;
  assign ro_termcount  = term_q;
  assign irq           = pend_q & ie_q;

endmodule

// File: tb/tb_timer_regs.sv
// Directed bench for timer_regs, built with a 5-bit address so 0x10 and up
// fall outside the register window.
module tb_timer_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        ro_trig_start;
  logic        ro_trig_halt;
  logic        ro_mode;
  logic [31:0] ro_termcount;
  logic        rf_status;
  logic [31:0] rf_currcount;
  logic        rf_int;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  timer_regs #(.ADDR_W(5), .TERM_RESET(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt),
    .ro_mode(ro_mode), .ro_termcount(ro_termcount),
    .rf_status(rf_status), .rf_currcount(rf_currcount), .rf_int(rf_int),
    .irq(irq)
  );

  // Starts and ends 1 ns after a rising edge; samples everything in the ack cycle.
  task automatic bus_xfer(input logic we, input logic [4:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd,
                          output logic st, output logic hl, output int lat);
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd; bus_wstrb = ws;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_ack && lat < 10);
    rd = bus_rdata; st = ro_trig_start; hl = ro_trig_halt;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic st, hl; int lat;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", bus_ack); end
    n_cmp++; if (bus_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", bus_rdata); end
    n_cmp++; if ({ro_trig_start, ro_trig_halt, ro_mode, irq} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=0000", {ro_trig_start, ro_trig_halt, ro_mode, irq});
    end
    n_cmp++; if (ro_termcount !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_term got=%h exp=ffffffff", ro_termcount); end
    reset = 1'b0;
    bus_xfer(1'b0, 5'h04, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL reset_read_lat got=%0d exp=1", lat); end
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_read_term got=%h exp=ffffffff", rd); end
    n_cmp++; if (bus_rdata !== 32'h0 || bus_ack !== 1'b0) begin
      n_bad++; $display("FAIL rdata_after_ack got=%h ack=%b exp=0/0", bus_rdata, bus_ack);
    end
  endtask

  task automatic test_term();
    logic [31:0] rd; logic st, hl; int lat;
    bus_xfer(1'b1, 5'h04, 32'h0000_0010, 4'b0011, rd, st, hl, lat);
    bus_xfer(1'b0, 5'h04, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (rd !== 32'hFFFF_0010) begin n_bad++; $display("FAIL term_partial got=%h exp=ffff0010", rd); end
    bus_xfer(1'b1, 5'h04, 32'h1234_5678, 4'b1111, rd, st, hl, lat);
    n_cmp++; if (ro_termcount !== 32'h1234_5678) begin n_bad++; $display("FAIL term_full got=%h exp=12345678", ro_termcount); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic st, hl; int lat;
    bus_xfer(1'b1, 5'h00, 32'h0000_000D, 4'b0001, rd, st, hl, lat);
    n_cmp++; if ({st, hl} !== 2'b10) begin n_bad++; $display("FAIL start_pulse got=%b exp=10", {st, hl}); end
    n_cmp++; if (ro_trig_start !== 1'b0) begin n_bad++; $display("FAIL start_width got=%b exp=0", ro_trig_start); end
    n_cmp++; if (ro_mode !== 1'b1) begin n_bad++; $display("FAIL mode_set got=%b exp=1", ro_mode); end
    bus_xfer(1'b0, 5'h00, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (rd !== 32'h0000_000C) begin n_bad++; $display("FAIL ctrl_read got=%h exp=0000000c", rd); end
    bus_xfer(1'b1, 5'h00, 32'h0000_0003, 4'b0001, rd, st, hl, lat);
    n_cmp++; if ({st, hl} !== 2'b01) begin n_bad++; $display("FAIL halt_priority got=%b exp=01", {st, hl}); end
    n_cmp++; if (ro_trig_halt !== 1'b0 || ro_mode !== 1'b0) begin
      n_bad++; $display("FAIL halt_after got=%b%b exp=00", ro_trig_halt, ro_mode);
    end
    bus_xfer(1'b1, 5'h00, 32'h0000_000D, 4'b1110, rd, st, hl, lat);
    n_cmp++; if ({st, ro_mode} !== 2'b00) begin n_bad++; $display("FAIL ctrl_nostrobe got=%b exp=00", {st, ro_mode}); end
  endtask

  task automatic test_pend();
    logic [31:0] rd; logic st, hl; int lat;
    bus_xfer(1'b1, 5'h00, 32'h0000_0008, 4'b0001, rd, st, hl, lat);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    rf_int = 1'b1;
    @(posedge clk); #1;
    rf_int = 1'b0;
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_xfer(1'b0, 5'h08, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (rd !== 32'h0000_0002) begin n_bad++; $display("FAIL status_pend got=%h exp=00000002", rd); end
    bus_xfer(1'b1, 5'h08, 32'h0000_0002, 4'b0001, rd, st, hl, lat);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_clear got=%b exp=0", irq); end
    // clear and a new terminal-count pulse on the same edge
    rf_int = 1'b1;
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'h08; bus_wdata = 32'h2; bus_wstrb = 4'b0001;
    @(posedge clk); #1;
    rf_int = 1'b0; bus_req = 1'b0; bus_we = 1'b0;
    n_cmp++; if (bus_ack !== 1'b1 || irq !== 1'b1) begin
      n_bad++; $display("FAIL w1c_vs_int got=ack%b irq%b exp=ack1 irq1", bus_ack, irq);
    end
    @(posedge clk); #1;
    bus_xfer(1'b1, 5'h00, 32'h0, 4'b0001, rd, st, hl, lat);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
    bus_xfer(1'b0, 5'h08, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (rd !== 32'h0000_0002) begin n_bad++; $display("FAIL pend_ie_indep got=%h exp=00000002", rd); end
    bus_xfer(1'b1, 5'h08, 32'h0000_0002, 4'b0001, rd, st, hl, lat);
  endtask

  task automatic test_readback();
    logic [31:0] rd; logic st, hl; int lat;
    rf_status = 1'b1; rf_currcount = 32'hCAFE_0001;
    bus_xfer(1'b0, 5'h0C, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (rd !== 32'hCAFE_0001) begin n_bad++; $display("FAIL count_read got=%h exp=cafe0001", rd); end
    bus_xfer(1'b0, 5'h08, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL status_run got=%h exp=00000001", rd); end
    bus_xfer(1'b1, 5'h00, 32'h0000_0001, 4'b0001, rd, st, hl, lat);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL start_running got=%b exp=1", st); end
    bus_xfer(1'b0, 5'h10, 32'h0, 4'h0, rd, st, hl, lat);
    n_cmp++; if (lat !== 1 || rd !== 32'h0) begin n_bad++; $display("FAIL oow_read got=lat%0d %h exp=lat1 0", lat, rd); end
    bus_xfer(1'b1, 5'h14, 32'h0, 4'b1111, rd, st, hl, lat);
    n_cmp++; if (lat !== 1 || ro_termcount !== 32'h1234_5678) begin
      n_bad++; $display("FAIL oow_write got=lat%0d %h exp=lat1 12345678", lat, ro_termcount);
    end
    rf_status = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] acks;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 5'h04;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      acks[i] = bus_ack;
    end
    bus_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (acks !== 3'b101) begin n_bad++; $display("FAIL b2b_acks got=%b exp=101", acks); end
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_end got=%b exp=0", bus_ack); end
  endtask

  task automatic test_reset_mid();
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'h00; bus_wdata = 32'h5; bus_wstrb = 4'b0001;
    @(posedge clk); #1;
    n_cmp++; if (bus_ack !== 1'b1 || ro_trig_start !== 1'b1) begin
      n_bad++; $display("FAIL mid_setup got=ack%b st%b exp=1/1", bus_ack, ro_trig_start);
    end
    reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({bus_ack, ro_trig_start, ro_trig_halt, ro_mode} !== 4'b0) begin
      n_bad++; $display("FAIL reset_mid got=%b exp=0000", {bus_ack, ro_trig_start, ro_trig_halt, ro_mode});
    end
    n_cmp++; if (ro_termcount !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_mid_term got=%h exp=ffffffff", ro_termcount); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL reset_mid_noack got=%b exp=0", bus_ack); end
  endtask

  initial begin
    reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    rf_status = 1'b0; rf_currcount = '0; rf_int = 1'b0;
    test_reset();
    test_term();
    test_ctrl();
    test_pend();
    test_readback();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
